audio_source_ctrl: RTL and testbench

Controller that shares the I2S sample FIFO between two stereo sample sources: source 0 (on-chip sine generator) and source 1 (processor/stream path). It grants exactly one source write access to the FIFO, and switches sources only through a zero-sample gap so the DAC never sees a torn frame or click. It also counts FIFO underruns seen by the I2S master. It sits between the sources and the FIFO write port, and taps the FIFO read side for monitoring.

---
 rtl/audio_source_ctrl_pkg.sv | 25 ++
 rtl/audio_underrun_counter.sv | 26 ++
 rtl/audio_source_ctrl.sv | 133 +++++++++++++
 tb/tb_audio_source_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_source_ctrl_pkg.sv
// Shared definitions for the audio source selection path: selection codes,
// controller state encoding and the stereo frame width helper.
package audio_source_ctrl_pkg;

    localparam logic [1:0] SEL_MUTE = 2'b00;
    localparam logic [1:0] SEL_SRC0 = 2'b01;
    localparam logic [1:0] SEL_SRC1 = 2'b10;

    typedef enum logic [1:0] {
        ST_PASS = 2'd0,
        ST_GAP  = 2'd1,
        ST_MUTE = 2'd2
    } state_t;

    // One FIFO word carries a full {left, right} frame.
    function automatic int frame_w(input int dw);
        return 2 * dw;
    endfunction

    // The unused code 2'b11 behaves as mute.
    function automatic logic [1:0] norm_sel(input logic [1:0] sel);
        return (sel == 2'b11) ? SEL_MUTE : sel;
    endfunction

endpackage

// File: rtl/audio_underrun_counter.sv
// Saturating event counter with synchronous clear; clear wins over a
// coincident event. Used for FIFO underruns, equally usable for overruns.
module audio_underrun_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Count qualifying events, holding at all-ones.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/audio_source_ctrl.sv
// Grants one of two stereo sources write access to the I2S sample FIFO and
// changes the grant only through a run of zero frames, so the DAC never sees
// a torn frame or an abrupt step. Also counts read-side underruns.
module audio_source_ctrl
    import audio_source_ctrl_pkg::*;
#(
    parameter int         DW         = 24,
    parameter int         GAP_FRAMES = 8,
    parameter logic [1:0] RESET_SEL  = 2'b01
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic [1:0]              sel_req,
    input  logic                    sel_req_valid,
    input  logic [frame_w(DW)-1:0]  src0_data,
    input  logic                    src0_valid,
    output logic                    src0_ready,
    input  logic [frame_w(DW)-1:0]  src1_data,
    input  logic                    src1_valid,
    output logic                    src1_ready,
    input  logic                    fifo_full,
    output logic                    fifo_wr,
    output logic [frame_w(DW)-1:0]  fifo_data,
    input  logic                    fifo_empty,
    input  logic                    fifo_rd,
    output logic [1:0]              cur_sel,
    output logic                    switching,
    output logic [15:0]             underrun_cnt,
    input  logic                    underrun_clr
);

    localparam logic [1:0] RST_SEL   = norm_sel(RESET_SEL);
    localparam state_t     RST_STATE = (RST_SEL == SEL_MUTE) ? ST_MUTE : ST_PASS;
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_FRAMES);

    state_t     state, state_nxt;
    logic [1:0] sel_q, sel_nxt;
    logic [1:0] target, target_nxt;
    logic [7:0] gap_cnt, gap_nxt;
    logic [1:0] req;

    assign req       = norm_sel(sel_req);
    assign cur_sel   = sel_q;
    assign switching = (state == ST_GAP);

    // State, grant, pending target and remaining gap frames.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state   <= RST_STATE;
            sel_q   <= RST_SEL;
            target  <= SEL_MUTE;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            sel_q   <= sel_nxt;
            target  <= target_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    // Next-state logic and the FIFO write-port mux.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel_q;
        target_nxt = target;
        gap_nxt    = gap_cnt;
        src0_ready = 1'b0;
        src1_ready = 1'b0;
        fifo_wr    = 1'b0;
        fifo_data  = '0;

        case (state)
            ST_PASS: begin
                if (sel_q == SEL_SRC0) begin
                    src0_ready = !fifo_full;
                    fifo_wr    = src0_valid && !fifo_full;
                    fifo_data  = src0_data;
                end else begin
                    src1_ready = !fifo_full;
                    fifo_wr    = src1_valid && !fifo_full;
                    fifo_data  = src1_data;
                end
                if (sel_req_valid && (req != sel_q)) begin
                    state_nxt  = ST_GAP;
                    target_nxt = req;
                    gap_nxt    = GAP_LOAD;
                end
            end

            ST_MUTE: begin
                fifo_wr = !fifo_full;
                if (sel_req_valid && (req != sel_q)) begin
                    state_nxt  = ST_GAP;
                    target_nxt = req;
                    gap_nxt    = GAP_LOAD;
                end
            end

            ST_GAP: begin
                fifo_wr = !fifo_full;
                // A late request only retargets; the gap keeps its length.
                if (sel_req_valid) begin
                    target_nxt = req;
                end
                if (!fifo_full) begin
                    gap_nxt = gap_cnt - 8'd1;
                    if (gap_cnt == 8'd1) begin
                        sel_nxt   = target_nxt;
                        state_nxt = (target_nxt == SEL_MUTE) ? ST_MUTE : ST_PASS;
                    end
                end
            end

            default: begin
                state_nxt = RST_STATE;
                sel_nxt   = RST_SEL;
            end
        endcase
    end

    audio_underrun_counter #(
        .WIDTH(16)
    ) u_underrun (
        .clk   (clk),
        .arst  (arst),
        .inc   (fifo_rd & fifo_empty),
        .clr   (underrun_clr),
        .count (underrun_cnt)
    );

endmodule

// File: tb/tb_audio_source_ctrl.sv
// Testbench for audio_source_ctrl: a table of cycle-by-cycle vectors for the
// basic switch, hand-written corner sequences, and a randomized run checked
// every cycle against a frame-counting reference model.
module tb_audio_source_ctrl;

    localparam int DW  = 24;
    localparam int FW  = 2 * DW;
    localparam int GAP = 8;

    logic          clk;
    logic          arst;
    logic [1:0]    sel_req;
    logic          sel_req_valid;
    logic [FW-1:0] src0_data;
    logic          src0_valid;
    logic          src0_ready;
    logic [FW-1:0] src1_data;
    logic          src1_valid;
    logic          src1_ready;
    logic          fifo_full;
    logic          fifo_wr;
    logic [FW-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_rd;
    logic [1:0]    cur_sel;
    logic          switching;
    logic [15:0]   underrun_cnt;
    logic          underrun_clr;

    // Narrow standalone counter so saturation is reachable in a few cycles.
    logic          sat_inc;
    logic          sat_clr;
    logic [3:0]    sat_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: granted source, pending target, zero frames still owed.
    int m_sel;
    int m_target;
    int m_gap_left;
    int m_cnt;

    audio_source_ctrl #(
        .DW         (DW),
        .GAP_FRAMES (GAP),
        .RESET_SEL  (2'b01)
    ) dut (
        .clk           (clk),
        .arst          (arst),
        .sel_req       (sel_req),
        .sel_req_valid (sel_req_valid),
        .src0_data     (src0_data),
        .src0_valid    (src0_valid),
        .src0_ready    (src0_ready),
        .src1_data     (src1_data),
        .src1_valid    (src1_valid),
        .src1_ready    (src1_ready),
        .fifo_full     (fifo_full),
        .fifo_wr       (fifo_wr),
        .fifo_data     (fifo_data),
        .fifo_empty    (fifo_empty),
        .fifo_rd       (fifo_rd),
        .cur_sel       (cur_sel),
        .switching     (switching),
        .underrun_cnt  (underrun_cnt),
        .underrun_clr  (underrun_clr)
    );

    audio_underrun_counter #(
        .WIDTH(4)
    ) u_sat (
        .clk   (clk),
        .arst  (arst),
        .inc   (sat_inc),
        .clr   (sat_clr),
        .count (sat_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sel      = 1;
        m_target   = 0;
        m_gap_left = 0;
        m_cnt      = 0;
    endtask

    task automatic model_check();
        logic          pass;
        logic          exp_wr;
        logic [FW-1:0] exp_data;
        pass     = (m_gap_left == 0) && (m_sel != 0);
        exp_wr   = pass ? (((m_sel == 1) ? src0_valid : src1_valid) && !fifo_full) : !fifo_full;
        exp_data = pass ? ((m_sel == 1) ? src0_data : src1_data) : '0;
        check("mdl_fifo_wr",      fifo_wr,      exp_wr);
        check("mdl_fifo_data",    fifo_data,    exp_data);
        check("mdl_src0_ready",   src0_ready,   pass && (m_sel == 1) && !fifo_full);
        check("mdl_src1_ready",   src1_ready,   pass && (m_sel == 2) && !fifo_full);
        check("mdl_cur_sel",      cur_sel,      m_sel);
        check("mdl_switching",    switching,    m_gap_left > 0);
        check("mdl_underrun_cnt", underrun_cnt, m_cnt);
    endtask

    task automatic model_step();
        int r;
        if (arst) begin
            model_reset();
        end else begin
            r = (sel_req == 2'b11) ? 0 : int'(sel_req);
            if (m_gap_left > 0) begin
                if (sel_req_valid) m_target = r;
                if (!fifo_full) begin
                    m_gap_left--;
                    if (m_gap_left == 0) m_sel = m_target;
                end
            end else if (sel_req_valid && (r != m_sel)) begin
                m_gap_left = GAP;
                m_target   = r;
            end
            if (underrun_clr) m_cnt = 0;
            else if (fifo_rd && fifo_empty && (m_cnt < 65535)) m_cnt++;
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are compared
    // on the falling edge; the model advances on the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (arst) model_reset();
        model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic       req_valid;
        logic [1:0] req;
        logic       full;
        logic       exp_wr;
        logic [1:0] exp_data;  // 0: zero frame, 1: src0_data, 2: src1_data
        logic [1:0] exp_sel;
        logic       exp_sw;
        logic       exp_r0;
        logic       exp_r1;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int zeros;
        int sw;
        int bad;
        logic done;
        logic [FW-1:0] want;

        // Switch src0 -> src1 with the FIFO never full.
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 1'b1, 2'd1, 2'b01, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 2'b10, 1'b0, 1'b1, 2'd1, 2'b01, 1'b0, 1'b1, 1'b0};
        for (int i = 2; i <= 9; i++)
            vecs[i] = '{1'b0, 2'b00, 1'b0, 1'b1, 2'd0, 2'b01, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 2'b00, 1'b0, 1'b1, 2'd2, 2'b10, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 2'b00, 1'b0, 1'b1, 2'd2, 2'b10, 1'b0, 1'b0, 1'b1};

        arst          = 1'b1;
        sel_req       = 2'b00;
        sel_req_valid = 1'b0;
        src0_data     = 48'h111111_222222;
        src1_data     = 48'h333333_444444;
        src0_valid    = 1'b1;
        src1_valid    = 1'b1;
        fifo_full     = 1'b0;
        fifo_empty    = 1'b0;
        fifo_rd       = 1'b0;
        underrun_clr  = 1'b0;
        sat_inc       = 1'b0;
        sat_clr       = 1'b0;
        model_reset();

        // Reset state.
        @(posedge clk);
        #1;
        fifo_full = 1'b1;
        #1;
        check("rst_wr_when_full", fifo_wr, 1'b0);
        fifo_full = 1'b0;
        #1;
        check("rst_cur_sel",    cur_sel,      2'b01);
        check("rst_switching",  switching,    1'b0);
        check("rst_underrun",   underrun_cnt, 16'h0);
        check("rst_fifo_wr",    fifo_wr,      1'b1);
        check("rst_src1_ready", src1_ready,   1'b0);
        cycle();
        arst = 1'b0;
        cycle();

        // Table-driven switch.
        for (int i = 0; i < 12; i++) begin
            sel_req_valid = vecs[i].req_valid;
            sel_req       = vecs[i].req;
            fifo_full     = vecs[i].full;
            #1;
            case (vecs[i].exp_data)
                2'd1:    want = src0_data;
                2'd2:    want = src1_data;
                default: want = '0;
            endcase
            check($sformatf("vec%0d_fifo_wr", i),    fifo_wr,    vecs[i].exp_wr);
            check($sformatf("vec%0d_fifo_data", i),  fifo_data,  want);
            check($sformatf("vec%0d_cur_sel", i),    cur_sel,    vecs[i].exp_sel);
            check($sformatf("vec%0d_switching", i),  switching,  vecs[i].exp_sw);
            check($sformatf("vec%0d_src0_ready", i), src0_ready, vecs[i].exp_r0);
            check($sformatf("vec%0d_src1_ready", i), src1_ready, vecs[i].exp_r1);
            cycle();
        end
        sel_req_valid = 1'b0;

        // Gap stalled by fifo_full for 5 cycles (src1 -> src0).
        sel_req       = 2'b01;
        sel_req_valid = 1'b1;
        cycle();
        sel_req_valid = 1'b0;
        zeros = 0; sw = 0; bad = 0; done = 1'b0;
        for (int j = 1; j <= 40 && !done; j++) begin
            fifo_full = (j >= 4) && (j <= 8);
            #1;
            if (switching) begin
                sw++;
                if (fifo_wr) zeros++;
            end else begin
                done = 1'b1;
            end
            if (fifo_wr && fifo_full) bad++;
            cycle();
        end
        fifo_full = 1'b0;
        check("stall_gap_ended",   done,    1'b1);
        check("stall_zero_writes", zeros,   8);
        check("stall_gap_cycles",  sw,      13);
        check("stall_no_wr_full",  bad,     0);
        check("stall_cur_sel",     cur_sel, 2'b01);

        // Retarget to mute three cycles into the gap.
        sel_req       = 2'b10;
        sel_req_valid = 1'b1;
        cycle();
        zeros = 0; sw = 0; done = 1'b0;
        for (int j = 1; j <= 40 && !done; j++) begin
            sel_req_valid = (j == 4);
            sel_req       = 2'b00;
            #1;
            if (switching) begin
                sw++;
                if (fifo_wr) zeros++;
            end else begin
                done = 1'b1;
            end
            cycle();
        end
        sel_req_valid = 1'b0;
        check("retarget_gap_ended",   done,    1'b1);
        check("retarget_zero_writes", zeros,   8);
        check("retarget_gap_cycles",  sw,      8);
        check("retarget_cur_sel",     cur_sel, 2'b00);
        for (int j = 0; j < 3; j++) begin
            #1;
            check("mute_fifo_wr",   fifo_wr,   1'b1);
            check("mute_fifo_data", fifo_data, 48'h0);
            cycle();
        end

        // Underrun counting, clear priority.
        fifo_rd    = 1'b1;
        fifo_empty = 1'b1;
        for (int j = 0; j < 3; j++) cycle();
        #1;
        check("underrun_three", underrun_cnt, 16'd3);
        underrun_clr = 1'b1;
        cycle();
        underrun_clr = 1'b0;
        fifo_empty   = 1'b0;
        cycle();
        check("underrun_cleared", underrun_cnt, 16'd0);
        fifo_rd = 1'b0;

        // Saturation and clear on the narrow counter.
        sat_inc = 1'b1;
        for (int j = 0; j < 20; j++) cycle();
        check("sat_hold_max", sat_count, 4'hF);
        sat_clr = 1'b1;
        cycle();
        check("sat_clear_priority", sat_count, 4'h0);
        sat_clr = 1'b0;
        cycle();
        check("sat_count_after_clear", sat_count, 4'h1);
        sat_inc = 1'b0;

        // Back to src0, then reset in the fourth gap cycle of a switch to src1.
        sel_req       = 2'b01;
        sel_req_valid = 1'b1;
        cycle();
        sel_req_valid = 1'b0;
        for (int j = 0; j < 20 && switching; j++) cycle();
        check("arst_setup_sel", cur_sel, 2'b01);
        sel_req       = 2'b10;
        sel_req_valid = 1'b1;
        cycle();
        sel_req_valid = 1'b0;
        for (int j = 0; j < 3; j++) cycle();
        check("arst_in_gap", switching, 1'b1);
        arst = 1'b1;
        #1;
        check("arst_cur_sel",   cur_sel,   2'b01);
        check("arst_switching", switching, 1'b0);
        check("arst_fifo_data", fifo_data, src0_data);
        cycle();
        arst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            #1;
            check("post_arst_switching", switching, 1'b0);
            check("post_arst_cur_sel",   cur_sel,   2'b01);
            cycle();
        end

        // Randomized traffic against the model.
        for (int j = 0; j < 600; j++) begin
            sel_req_valid = ($urandom % 12) == 0;
            sel_req       = 2'($urandom);
            src0_valid    = 1'($urandom);
            src1_valid    = 1'($urandom);
            src0_data     = {16'($urandom), 32'($urandom)};
            src1_data     = {16'($urandom), 32'($urandom)};
            fifo_full     = ($urandom % 4) == 0;
            fifo_rd       = 1'($urandom);
            fifo_empty    = 1'($urandom);
            underrun_clr  = ($urandom % 40) == 0;
            arst          = ($urandom % 150) == 0;
            cycle();
        end
        arst = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
